// File: rtl/prbs_pkg.sv
// Shared PRBS7 definitions for the BER controller and the PRBS7 generator.
//   ber_state_t       : controller sequencing states
//   PRBS7_SEED        : generator seed / checker history reset value
//   PRBS7_TAP_A/B     : history bit positions feeding the XNOR feedback
//   ERR_RATE_DISABLED : injection interval that effectively disables injection
package prbs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GEN_RST = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_SYNC    = 3'd3,
    ST_MEASURE = 3'd4,
    ST_DONE    = 3'd5
  } ber_state_t;

  localparam logic [6:0]  PRBS7_SEED        = 7'h7F;
  localparam int unsigned PRBS7_TAP_A       = 6;
  localparam int unsigned PRBS7_TAP_B       = 5;
  localparam logic [15:0] ERR_RATE_DISABLED = 16'hFFFF;
  localparam int unsigned SYNC_CYCLES       = 7;

  // Next PRBS7 bit from a 7-bit history (bit 6 oldest), XNOR feedback.
  function automatic logic prbs7_next(input logic [6:0] hist);
    return ~(hist[PRBS7_TAP_A] ^ hist[PRBS7_TAP_B]);
  endfunction

endpackage

// File: rtl/prbs_ber_controller_if.sv
// Host/datapath bundle of the PRBS BER controller.
//   master : host side (drives run control and the looped-back rx bit)
//   slave  : controller side (drives generator control, status and counts)
interface prbs_ber_controller_if #(
  parameter int unsigned CNT_W = 32
);

  logic             start;
  logic             abort;
  logic [CNT_W-1:0] test_len;
  logic [15:0]      err_interval;
  logic             inject_en;
  logic             rx_bit;
  logic             gen_rst;
  logic [15:0]      gen_error_rate;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bit_count;
  logic [CNT_W-1:0] err_count;

  modport master (
    output start, abort, test_len, err_interval, inject_en, rx_bit,
    input  gen_rst, gen_error_rate, busy, done, bit_count, err_count
  );

  modport slave (
    input  start, abort, test_len, err_interval, inject_en, rx_bit,
    output gen_rst, gen_error_rate, busy, done, bit_count, err_count
  );

endinterface

// File: rtl/prbs7_checker.sv
// PRBS7 reference checker: owns the 7-bit history and predicts the next bit.
//   clk, rst  : clock, synchronous active-high reset (history -> seed)
//   load      : shift rx_bit into the history (synchronisation)
//   check     : shift the predicted bit into the history (locked compare)
//   rx_bit    : received bit
//   exp       : predicted bit from the current history (combinational)
//   mismatch  : rx_bit differs from exp (combinational)
module prbs7_checker
  import prbs_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic check,
  input  logic rx_bit,
  output logic exp,
  output logic mismatch
);

  logic [6:0] hist_q;
  logic [6:0] hist_d;

  assign exp      = prbs7_next(hist_q);
  assign mismatch = rx_bit ^ exp;

  // Once locked the prediction feeds itself, so a flipped rx bit cannot
  // corrupt later predictions and is counted exactly once.
  always_comb begin
    hist_d = hist_q;
    if (load) begin
      hist_d = {hist_q[5:0], rx_bit};
    end else if (check) begin
      hist_d = {hist_q[5:0], exp};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= PRBS7_SEED;
    end else begin
      hist_q <= hist_d;
    end
  end

endmodule

// File: rtl/prbs_ber_controller.sv
// Sequencing controller for one PRBS7 bit-error-rate run: resets/configures
// the generator, synchronises the local reference, then counts compared bits
// and mismatches for the latched length.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of prbs_ber_controller_if
//              (start/abort/test_len/err_interval/inject_en/rx_bit in,
//               gen_rst/gen_error_rate/busy/done/bit_count/err_count out)
module prbs_ber_controller
  import prbs_pkg::*;
#(
  parameter int unsigned GEN_RST_CYCLES = 2,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  prbs_ber_controller_if.slave  bus
);

  localparam int unsigned PH_MAX_GS = (GEN_RST_CYCLES > SETTLE_CYCLES) ? GEN_RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned PH_MAX    = (PH_MAX_GS > SYNC_CYCLES) ? PH_MAX_GS : SYNC_CYCLES;
  localparam int unsigned PH_W      = $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0] GEN_LAST    = PH_W'(GEN_RST_CYCLES - 1);
  localparam logic [PH_W-1:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? '0 : PH_W'(SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0] SYNC_LAST   = PH_W'(SYNC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  ber_state_t       state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [15:0]      rate_q, rate_d;
  logic [CNT_W-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             gen_rst_q, gen_rst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             load_c;
  logic             check_c;
  logic             exp_c;
  logic             mismatch_c;

  prbs7_checker u_checker (
    .clk      (clk),
    .rst      (rst),
    .load     (load_c),
    .check    (check_c),
    .rx_bit   (bus.rx_bit),
    .exp      (exp_c),
    .mismatch (mismatch_c)
  );

  // Next state, phase counter, latched configuration and counters.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    len_d   = len_q;
    rate_d  = rate_q;
    bit_d   = bit_q;
    err_d   = err_q;
    load_c  = 1'b0;
    check_c = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start && !bus.abort) begin
          state_d = ST_GEN_RST;
          ph_d    = '0;
          len_d   = bus.test_len;
          rate_d  = bus.inject_en ? bus.err_interval : ERR_RATE_DISABLED;
          bit_d   = '0;
          err_d   = '0;
        end
      end
      ST_GEN_RST: begin
        if (ph_q == GEN_LAST) begin
          ph_d    = '0;
          state_d = (SETTLE_CYCLES == 0) ? ST_SYNC : ST_SETTLE;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_SETTLE: begin
        if (ph_q == SETTLE_LAST) begin
          ph_d    = '0;
          state_d = ST_SYNC;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_SYNC: begin
        load_c = 1'b1;
        if (ph_q == SYNC_LAST) begin
          ph_d    = '0;
          state_d = (len_q == '0) ? ST_DONE : ST_MEASURE;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_MEASURE: begin
        check_c = 1'b1;
        bit_d   = bit_q + CNT_W'(1);
        if (mismatch_c && (err_q != CNT_MAX)) begin
          err_d = err_q + CNT_W'(1);
        end
        if (bit_d == len_q) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides everything while a run is in flight; counts are kept.
    if (bus.abort && busy_q) begin
      state_d = ST_IDLE;
      ph_d    = '0;
      len_d   = len_q;
      rate_d  = rate_q;
      bit_d   = bit_q;
      err_d   = err_q;
      load_c  = 1'b0;
      check_c = 1'b0;
    end

    gen_rst_d = (state_d == ST_GEN_RST);
    busy_d    = (state_d == ST_GEN_RST) || (state_d == ST_SETTLE) ||
                (state_d == ST_SYNC)    || (state_d == ST_MEASURE);
    done_d    = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ph_q      <= '0;
      len_q     <= '0;
      rate_q    <= ERR_RATE_DISABLED;
      bit_q     <= '0;
      err_q     <= '0;
      gen_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      len_q     <= len_d;
      rate_q    <= rate_d;
      bit_q     <= bit_d;
      err_q     <= err_d;
      gen_rst_q <= gen_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.gen_rst        = gen_rst_q;
  assign bus.gen_error_rate = rate_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.bit_count      = bit_q;
  assign bus.err_count      = err_q;

endmodule

// File: tb/tb_prbs_ber_controller.sv
// Self-checking bench for prbs_ber_controller: a PRBS7 stream built from the
// recurrence b[n] = ~(b[n-7] ^ b[n-6]) drives rx_bit; expected timing and
// counts come from the run arithmetic and a direct stream comparison.
module tb_prbs_ber_controller;

  localparam int G_MAIN = 2;
  localparam int S_MAIN = 4;
  localparam int G_SMALL = 1;
  localparam int S_SMALL = 0;
  localparam int SMALL_MAX = 15;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  prbs_ber_controller_if #(.CNT_W(32)) bus ();
  prbs_ber_controller_if #(.CNT_W(4))  bus_s ();

  prbs_ber_controller #(.GEN_RST_CYCLES(G_MAIN), .SETTLE_CYCLES(S_MAIN), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  prbs_ber_controller #(.GEN_RST_CYCLES(G_SMALL), .SETTLE_CYCLES(S_SMALL), .CNT_W(4)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit ref_a [4096];
  bit rx_a  [4096];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, want, want);
    end
  endtask

  // Reference stream: 7 random sync bits, then the PRBS7 recurrence.
  task automatic build_stream(input int len, input bit random_rx, input bit invert);
    for (int n = 0; n < 7; n++) begin
      ref_a[n] = 1'($urandom);
      rx_a[n]  = ref_a[n];
    end
    for (int n = 7; n < 7 + len; n++) begin
      ref_a[n] = ~(ref_a[n-7] ^ ref_a[n-6]);
      rx_a[n]  = random_rx ? 1'($urandom) : (ref_a[n] ^ invert);
    end
  endtask

  task automatic flip_measured(input int idx);
    rx_a[7 + idx] = ~rx_a[7 + idx];
  endtask

  // Mismatches among the first n measured bits.
  function automatic int model_errs(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (rx_a[7 + i] != ref_a[7 + i]) c++;
    return c;
  endfunction

  // stop_kind: 0 full run, 1 abort, 2 start+abort, 3 rst at edge stop_at.
  task automatic run_main(input string tag, input int len, input bit inj, input logic [15:0] ival,
                          input int stop_kind, input int stop_at, input bit poke);
    int gen_hi, gen_last, done_k, k_end;
    @(posedge clk); #1;
    bus.test_len     = 32'(len);
    bus.inject_en    = inj;
    bus.err_interval = ival;
    bus.start        = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    gen_hi = 0; gen_last = -1; done_k = -1; k_end = 0;
    if (bus.gen_rst) begin gen_hi++; gen_last = 0; end
    check_eq({tag, " busy_after_start"}, 32'(bus.busy), 32'd1);
    check_eq({tag, " gen_error_rate"}, 32'(bus.gen_error_rate), inj ? 32'(ival) : 32'hFFFF);
    for (int k = 1; k <= len + 100; k++) begin
      bus.rx_bit = (k >= 7 && (k - 7) < 4096) ? rx_a[k-7] : 1'($urandom);
      if (poke && k == 200) begin
        bus.start    = 1'b1;
        bus.test_len = 32'd5;
      end
      if (stop_kind != 0 && k == stop_at) begin
        if (stop_kind == 1) bus.abort = 1'b1;
        if (stop_kind == 2) begin bus.abort = 1'b1; bus.start = 1'b1; end
        if (stop_kind == 3) rst = 1'b1;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      rst       = 1'b0;
      k_end = k;
      if (bus.gen_rst) begin gen_hi++; gen_last = k; end
      if (stop_kind != 0 && k == stop_at) break;
      if (bus.done) begin done_k = k; break; end
    end
    if (stop_kind == 0) begin
      check_eq({tag, " done_edge"}, 32'(done_k), 32'(G_MAIN + S_MAIN + 7 + len));
      check_eq({tag, " gen_rst_cycles"}, 32'(gen_hi), 32'(G_MAIN));
      check_eq({tag, " gen_rst_last"}, 32'(gen_last), 32'(G_MAIN - 1));
      check_eq({tag, " bit_count"}, bus.bit_count, 32'(len));
      check_eq({tag, " err_count"}, bus.err_count, 32'(model_errs(len)));
      check_eq({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      check_eq({tag, " done_held"}, 32'(bus.done), 32'd1);
    end else if (stop_kind == 3) begin
      check_eq({tag, " rst_busy"}, 32'(bus.busy), 32'd0);
      check_eq({tag, " rst_done"}, 32'(bus.done), 32'd0);
      check_eq({tag, " rst_gen_rst"}, 32'(bus.gen_rst), 32'd0);
      check_eq({tag, " rst_rate"}, 32'(bus.gen_error_rate), 32'hFFFF);
      check_eq({tag, " rst_bit_count"}, bus.bit_count, 32'd0);
      check_eq({tag, " rst_err_count"}, bus.err_count, 32'd0);
    end else begin
      check_eq({tag, " stop_edge"}, 32'(k_end), 32'(stop_at));
      check_eq({tag, " abort_busy"}, 32'(bus.busy), 32'd0);
      check_eq({tag, " abort_done"}, 32'(bus.done), 32'd0);
      check_eq({tag, " abort_gen_rst"}, 32'(bus.gen_rst), 32'd0);
      check_eq({tag, " abort_bit_count"}, bus.bit_count, 32'(stop_at - 14));
      check_eq({tag, " abort_err_count"}, bus.err_count, 32'(model_errs(stop_at - 14)));
      repeat (3) @(posedge clk);
      #1;
      check_eq({tag, " idle_stays"}, 32'(bus.busy), 32'd0);
    end
  endtask

  // Small-width instance: no settle phase, 4-bit counters.
  task automatic run_small(input string tag, input int len);
    int done_k, e;
    @(posedge clk); #1;
    bus_s.test_len  = 4'(len);
    bus_s.inject_en = 1'b0;
    bus_s.start     = 1'b1;
    @(posedge clk); #1;
    bus_s.start = 1'b0;
    done_k = -1;
    for (int k = 1; k <= len + 40; k++) begin
      bus_s.rx_bit = (k >= G_SMALL + S_SMALL + 1) ? rx_a[k - (G_SMALL + S_SMALL + 1)] : 1'($urandom);
      @(posedge clk); #1;
      if (bus_s.done) begin done_k = k; break; end
    end
    e = model_errs(len);
    if (e > SMALL_MAX) e = SMALL_MAX;
    check_eq({tag, " done_edge"}, 32'(done_k), 32'(G_SMALL + S_SMALL + 7 + len));
    check_eq({tag, " bit_count"}, 32'(bus_s.bit_count), 32'(len));
    check_eq({tag, " err_count"}, 32'(bus_s.err_count), 32'(e));
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.test_len = '0; bus.err_interval = '0;
    bus.inject_en = 1'b0; bus.rx_bit = 1'b0;
    bus_s.start = 1'b0; bus_s.abort = 1'b0; bus_s.test_len = '0; bus_s.err_interval = '0;
    bus_s.inject_en = 1'b0; bus_s.rx_bit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check_eq("reset busy", 32'(bus.busy), 32'd0);
    check_eq("reset done", 32'(bus.done), 32'd0);
    check_eq("reset gen_rst", 32'(bus.gen_rst), 32'd0);
    check_eq("reset rate", 32'(bus.gen_error_rate), 32'hFFFF);
    check_eq("reset bit_count", bus.bit_count, 32'd0);
    check_eq("reset err_count", bus.err_count, 32'd0);

    build_stream(1000, 1'b0, 1'b0);
    run_main("clean", 1000, 1'b0, 16'd99, 0, 0, 1'b0);

    build_stream(1000, 1'b0, 1'b0);
    flip_measured(500);
    run_main("flip1", 1000, 1'b1, 16'd99, 0, 0, 1'b1);

    build_stream(1000, 1'b0, 1'b0);
    flip_measured(10); flip_measured(300); flip_measured(777);
    run_main("flip3", 1000, 1'b0, 16'd7, 0, 0, 1'b0);

    build_stream(0, 1'b0, 1'b0);
    run_main("len0", 0, 1'b1, 16'd1234, 0, 0, 1'b0);

    build_stream(2000, 1'b1, 1'b0);
    run_main("random", 2000, 1'b0, 16'd0, 0, 0, 1'b0);

    build_stream(1000, 1'b0, 1'b0);
    flip_measured(100); flip_measured(600);
    run_main("abort", 1000, 1'b0, 16'd0, 1, 500, 1'b0);

    build_stream(300, 1'b0, 1'b0);
    flip_measured(42);
    run_main("rerun", 300, 1'b1, 16'd500, 0, 0, 1'b0);

    build_stream(1000, 1'b0, 1'b0);
    flip_measured(20);
    run_main("start_abort", 1000, 1'b0, 16'd0, 2, 400, 1'b0);

    build_stream(1000, 1'b0, 1'b0);
    run_main("rst_mid", 1000, 1'b1, 16'd99, 3, 300, 1'b0);

    build_stream(15, 1'b0, 1'b1);
    run_small("small_sat", 15);

    build_stream(12, 1'b0, 1'b0);
    flip_measured(3); flip_measured(9);
    run_small("small_flip", 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs_ber_controller.md
# prbs_ber_controller

Sequencing controller for one PRBS7 bit-error-rate test run. It resets and configures the PRBS7 generator (XNOR taps 7,6, all-ones seed, periodic error injection), synchronises a local PRBS7 reference to the looped-back receive bit, then counts compared bits and mismatches for a programmed length. It sits between the register/host interface and the generator/fibre-loopback datapath.

## Interface
- `GEN_RST_CYCLES`, default 2: cycles `gen_rst` is held high per run (≥1).
- `SETTLE_CYCLES`, default 4: received bits discarded after generator reset, covering link latency (≥0).
- `CNT_W`, default 32: width of `test_len`, `bit_count` and `err_count`.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin a run; honoured only in IDLE or DONE.
- `abort` in 1: terminate a run; returns to IDLE.
- `test_len` in CNT_W: number of bits to compare.
- `err_interval` in 16: injection interval passed to the generator.
- `inject_en` in 1: 0 drives 16'hFFFF to the generator.
- `rx_bit` in 1: received bit, one per clk.
- `gen_rst` out 1: generator reset.
- `gen_error_rate` out 16: generator injection interval.
- `busy` out 1: run in progress.
- `done` out 1: run completed; held until the next start.
- `bit_count` out CNT_W: bits compared.
- `err_count` out CNT_W: mismatches; saturates at all-ones.

## Operation
- FSM states: IDLE, GEN_RST, SETTLE, SYNC, MEASURE, DONE.
- IDLE or DONE with `start` → GEN_RST.
  - Latch `test_len`.
  - Latch `gen_error_rate` = `inject_en` ? `err_interval` : 16'hFFFF.
  - Clear `bit_count` and `err_count`.
  - Clear `done`.
- GEN_RST: `gen_rst`=1 for GEN_RST_CYCLES cycles → SETTLE.
- SETTLE: `rx_bit` ignored for SETTLE_CYCLES cycles. If SETTLE_CYCLES=0, pass straight to SYNC.
- SYNC: 7 cycles. Each cycle shift `rx_bit` into the 7-bit history register `hist` (`hist[6]` oldest) → MEASURE. If the latched `test_len`=0, go → DONE instead.
- MEASURE (locked reference), every cycle:
  - Expected bit `exp` = ~(`hist[6]` ^ `hist[5]`).
  - `bit_count` increments by 1.
  - `err_count` increments by 1 if `rx_bit` != `exp`, saturating at all-ones.
  - `exp` is shifted into `hist`, not `rx_bit`, so each single flipped bit counts exactly once.
  - When the incremented `bit_count` equals the latched length → DONE.
- DONE: `done`=1. Counts are frozen and remain readable.
- `abort` while `busy` → IDLE on the next cycle.
  - `gen_rst`=0.
  - `bit_count` and `err_count` are retained.
  - `done` stays 0.
- `abort` and `start` sampled in the same cycle: `abort` wins.
- `start` while `busy`: ignored.
- `test_len` and `err_interval` changes mid-run: no effect.
- With `inject_en`=0 the generator still flips one bit per 65536. Runs with `test_len` ≤ 65535 after sync therefore see no injected error.

## Timing
- Reset values:
  - State IDLE.
  - `gen_rst`=0, `busy`=0, `done`=0.
  - `gen_error_rate`=16'hFFFF.
  - `bit_count`=0, `err_count`=0.
  - `hist`=7'h7F.
- `rst` mid-run has the same effect as reset; `gen_rst` drops the next cycle.
- All outputs are registered.
- `busy` rises the cycle after `start` is sampled. It falls on the same edge `done` rises.
- `gen_rst` is high in cycles 1..GEN_RST_CYCLES after `start` is sampled.
- `done` rises GEN_RST_CYCLES + SETTLE_CYCLES + 7 + `test_len` + 1 cycles after `start` is sampled. With `test_len`=0 it rises at GEN_RST_CYCLES + SETTLE_CYCLES + 8.
- `bit_count` and `err_count` reflect a compared bit one cycle after that bit is sampled.

## Structure
- Package `prbs_pkg`:
  - State enum `ber_state_t`.
  - `PRBS7_SEED` = 7'h7F.
  - `PRBS7_TAP_A` = 6, `PRBS7_TAP_B` = 5.
  - `ERR_RATE_DISABLED` = 16'hFFFF.
  - Shared with the generator.
- Sub-module `prbs7_checker`: owns `hist`.
  - Ports: `load` (SYNC shift), `check` (MEASURE shift of `exp`), `rx_bit`.
  - Outputs: `exp`, `mismatch`.
- The FSM, phase counter and saturating counters stay in the top module.

## Test plan
- Clean PRBS7 stream from the bench model, started with `rx_bit` aligned after SETTLE, `test_len`=1000, defaults → `gen_rst` high cycles 1–2; `done` at cycle 1014; `bit_count`=1000; `err_count`=0.
- Same stream with measured bit 500 flipped → `err_count`=1 exactly.
- Same stream with three non-adjacent bits flipped → `err_count`=3.
- `inject_en`=1, `err_interval`=99 → `gen_error_rate`=99. With `inject_en`=0 → `gen_error_rate`=16'hFFFF.
- `test_len`=0 → `done` at cycle 14, `bit_count`=0. Random stream → `err_count`≈`bit_count`/2; preset the counter near all-ones → `err_count` holds at all-ones.
- Mid-MEASURE sequence:
  - `abort` → IDLE next cycle, counts retained, `done`=0.
  - Subsequent `start` → counts cleared and a full run completes.
  - `start` and `abort` in the same cycle → IDLE.
  - `rst` mid-run → all reset values.
